// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// and fills the IF/ID register, handling stalls, redirects and out-of-range halt.
module estagio_busca #(
    parameter logic [31:0] PC_INICIAL = 32'd0,
    parameter int unsigned TAM_MEM    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    input  logic [31:0] instrucao,
    output logic [31:0] endereco,
    output logic [31:0] instrucao_id,
    output logic [31:0] pc_mais4_id,
    output logic        valido_id,
    output logic        parado,
    output logic        erro_alinhamento,
    output logic [31:0] instrucoes_emitidas
);

    localparam logic [31:0] LIMITE = 32'(4 * TAM_MEM);

    typedef enum logic {
        BUSCA = 1'b0,
        FIM   = 1'b1
    } estado_t;

    estado_t     estado_q, estado_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [31:0] pc_mais4_id_q, pc_mais4_id_d;
    logic        valido_id_q, valido_id_d;
    logic        erro_q, erro_d;
    logic [31:0] emitidas_q, emitidas_d;

    logic [31:0] pc_mais4;
    logic [31:0] alvo_alinhado;
    logic        em_faixa;

    assign pc_mais4      = pc_q + 32'd4;
    assign alvo_alinhado = {alvo_desvio[31:2], 2'b00};
    assign em_faixa      = (pc_q < LIMITE);

    // Next-state: desvio beats stall, stall beats normal fetch.
    always_comb begin
        estado_d      = estado_q;
        pc_d          = pc_q;
        instr_id_d    = instr_id_q;
        pc_mais4_id_d = pc_mais4_id_q;
        valido_id_d   = valido_id_q;
        erro_d        = erro_q;
        emitidas_d    = emitidas_q;

        if (desvio) begin
            pc_d        = alvo_alinhado;
            instr_id_d  = 32'd0;
            valido_id_d = 1'b0;
            if (alvo_desvio[1:0] != 2'b00) begin
                erro_d = 1'b1;
            end
            estado_d = (alvo_alinhado < LIMITE) ? BUSCA : FIM;
        end else if (!stall) begin
            if (estado_q == BUSCA && em_faixa) begin
                instr_id_d    = instrucao;
                pc_mais4_id_d = pc_mais4;
                valido_id_d   = 1'b1;
                pc_d          = pc_mais4;
                emitidas_d    = emitidas_q + 32'd1;
            end else begin
                // Out of range or already halted: keep PC, feed bubbles.
                estado_d    = FIM;
                instr_id_d  = 32'd0;
                valido_id_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= BUSCA;
            pc_q          <= PC_INICIAL;
            instr_id_q    <= 32'd0;
            pc_mais4_id_q <= 32'd0;
            valido_id_q   <= 1'b0;
            erro_q        <= 1'b0;
            emitidas_q    <= 32'd0;
        end else begin
            estado_q      <= estado_d;
            pc_q          <= pc_d;
            instr_id_q    <= instr_id_d;
            pc_mais4_id_q <= pc_mais4_id_d;
            valido_id_q   <= valido_id_d;
            erro_q        <= erro_d;
            emitidas_q    <= emitidas_d;
        end
    end

    assign endereco            = pc_q;
    assign parado              = (estado_q == FIM);
    assign instrucao_id        = instr_id_q;
    assign pc_mais4_id         = pc_mais4_id_q;
    assign valido_id           = valido_id_q;
    assign erro_alinhamento    = erro_q;
    assign instrucoes_emitidas = emitidas_q;

endmodule

// File: tb/tb_estagio_busca.sv
// Directed bench for estagio_busca with a 32-word combinational instruction memory.
module tb_estagio_busca;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        desvio;
    logic [31:0] alvo_desvio;
    logic [31:0] instrucao;
    logic [31:0] endereco;
    logic [31:0] instrucao_id;
    logic [31:0] pc_mais4_id;
    logic        valido_id;
    logic        parado;
    logic        erro_alinhamento;
    logic [31:0] instrucoes_emitidas;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:31];

    estagio_busca #(.PC_INICIAL(32'd0), .TAM_MEM(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .desvio             (desvio),
        .alvo_desvio        (alvo_desvio),
        .instrucao          (instrucao),
        .endereco           (endereco),
        .instrucao_id       (instrucao_id),
        .pc_mais4_id        (pc_mais4_id),
        .valido_id          (valido_id),
        .parado             (parado),
        .erro_alinhamento   (erro_alinhamento),
        .instrucoes_emitidas(instrucoes_emitidas)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        if (endereco < 32'd128) instrucao = mem[endereco[6:2]];
        else                    instrucao = 32'hDEADBEEF;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[0] = 32'h01095020;
        mem[1] = 32'h02119020;
        mem[2] = 32'h02939822;

        reset = 1'b1; stall = 1'b0; desvio = 1'b0; alvo_desvio = 32'd0;
        tick();
        chk("rst_pc", endereco, 32'd0);
        chk("rst_valido", 32'(valido_id), 32'd0);
        chk("rst_instr", instrucao_id, 32'd0);
        chk("rst_pc4", pc_mais4_id, 32'd0);
        chk("rst_count", instrucoes_emitidas, 32'd0);
        chk("rst_parado", 32'(parado), 32'd0);
        chk("rst_erro", 32'(erro_alinhamento), 32'd0);

        reset = 1'b0;
        tick();
        chk("f0_pc", endereco, 32'd4);
        chk("f0_instr", instrucao_id, 32'h01095020);
        chk("f0_valido", 32'(valido_id), 32'd1);
        chk("f0_pc4", pc_mais4_id, 32'd4);
        tick();
        chk("f1_pc", endereco, 32'd8);
        chk("f1_instr", instrucao_id, 32'h02119020);
        chk("f1_pc4", pc_mais4_id, 32'd8);
        chk("f1_count", instrucoes_emitidas, 32'd2);

        // Two-cycle stall at pc=8
        stall = 1'b1;
        tick();
        chk("st0_pc", endereco, 32'd8);
        chk("st0_instr", instrucao_id, 32'h02119020);
        chk("st0_count", instrucoes_emitidas, 32'd2);
        tick();
        chk("st1_pc", endereco, 32'd8);
        chk("st1_instr", instrucao_id, 32'h02119020);
        chk("st1_valido", 32'(valido_id), 32'd1);
        stall = 1'b0;
        tick();
        chk("f2_pc", endereco, 32'd12);
        chk("f2_instr", instrucao_id, 32'h02939822);
        chk("f2_pc4", pc_mais4_id, 32'd12);
        chk("f2_count", instrucoes_emitidas, 32'd3);

        // Branch together with stall: branch wins
        desvio = 1'b1; alvo_desvio = 32'd80; stall = 1'b1;
        tick();
        chk("br_pc", endereco, 32'd80);
        chk("br_valido", 32'(valido_id), 32'd0);
        chk("br_instr", instrucao_id, 32'd0);
        chk("br_pc4_hold", pc_mais4_id, 32'd12);
        chk("br_count", instrucoes_emitidas, 32'd3);
        desvio = 1'b0; stall = 1'b0;
        tick();
        chk("br_tgt_instr", instrucao_id, 32'hA0000014);
        chk("br_tgt_pc4", pc_mais4_id, 32'd84);
        chk("br_tgt_pc", endereco, 32'd84);
        chk("br_tgt_count", instrucoes_emitidas, 32'd4);

        // Misaligned target
        desvio = 1'b1; alvo_desvio = 32'd22;
        tick();
        chk("mis_pc", endereco, 32'd20);
        chk("mis_erro", 32'(erro_alinhamento), 32'd1);
        chk("mis_valido", 32'(valido_id), 32'd0);
        desvio = 1'b0;
        tick();
        chk("mis_instr", instrucao_id, 32'hA0000005);
        chk("mis_pc_next", endereco, 32'd24);
        chk("mis_erro_sticky", 32'(erro_alinhamento), 32'd1);
        chk("mis_count", instrucoes_emitidas, 32'd5);

        // Run to the last word and past the end
        for (int i = 0; i < 25; i++) tick();
        chk("end_pc124", endereco, 32'd124);
        chk("end_count30", instrucoes_emitidas, 32'd30);
        chk("end_parado0", 32'(parado), 32'd0);
        tick();
        chk("last_instr", instrucao_id, 32'hA000001F);
        chk("last_pc", endereco, 32'd128);
        chk("last_pc4", pc_mais4_id, 32'd128);
        chk("last_count", instrucoes_emitidas, 32'd31);
        tick();
        chk("fim_parado", 32'(parado), 32'd1);
        chk("fim_valido", 32'(valido_id), 32'd0);
        chk("fim_instr", instrucao_id, 32'd0);
        chk("fim_pc", endereco, 32'd128);
        chk("fim_count", instrucoes_emitidas, 32'd31);
        tick();
        chk("fim2_parado", 32'(parado), 32'd1);
        chk("fim2_pc", endereco, 32'd128);
        chk("fim2_count", instrucoes_emitidas, 32'd31);
        chk("fim2_erro", 32'(erro_alinhamento), 32'd1);

        // Leave FIM by branch
        desvio = 1'b1; alvo_desvio = 32'd20;
        tick();
        chk("res_parado", 32'(parado), 32'd0);
        chk("res_pc", endereco, 32'd20);
        desvio = 1'b0;
        tick();
        chk("res_instr", instrucao_id, 32'hA0000005);
        chk("res_pc_next", endereco, 32'd24);
        chk("res_count", instrucoes_emitidas, 32'd32);

        // Branch straight out of range halts immediately
        desvio = 1'b1; alvo_desvio = 32'd200;
        tick();
        chk("oor_parado", 32'(parado), 32'd1);
        chk("oor_pc", endereco, 32'd200);
        desvio = 1'b0;
        tick();
        chk("oor_hold_pc", endereco, 32'd200);
        chk("oor_hold_count", instrucoes_emitidas, 32'd32);

        // Reset together with a misaligned branch: reset wins
        reset = 1'b1; desvio = 1'b1; alvo_desvio = 32'd42;
        tick();
        chk("rst2_pc", endereco, 32'd0);
        chk("rst2_valido", 32'(valido_id), 32'd0);
        chk("rst2_count", instrucoes_emitidas, 32'd0);
        chk("rst2_parado", 32'(parado), 32'd0);
        chk("rst2_erro", 32'(erro_alinhamento), 32'd0);
        reset = 1'b0; desvio = 1'b0;
        tick();
        chk("rst2_instr", instrucao_id, 32'h01095020);
        chk("rst2_count1", instrucoes_emitidas, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/estagio_busca.md
# estagio_busca

Instruction-fetch (IF) stage of the 5-stage MIPS-32 pipeline. It owns the program counter and drives `endereco` into the instruction memory. The memory returns `instrucao` combinationally in the same cycle, and this block latches it into the IF/ID pipeline register for the decode stage. The block handles load-use stalls from the hazard unit, branch redirects and flushes from the branch-resolution stage, and halts cleanly when the PC leaves the populated instruction memory.

## Interface
Parameters:
- PC_INICIAL, 32'd0: PC value loaded on reset.
- TAM_MEM, 32: instruction memory depth in words. Valid byte addresses are 0 .. 4*TAM_MEM-4.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- desvio  in  1  branch/jump taken. Redirect the PC and flush IF/ID.
- alvo_desvio  in  32  branch target byte address.
- instrucao  in  32  word returned by the instruction memory for `endereco`.
- endereco  out  32  current PC. Equals the PC register, combinational to memory.
- instrucao_id  out  32  IF/ID instruction.
- pc_mais4_id  out  32  IF/ID copy of PC+4 for the fetched instruction.
- valido_id  out  1  IF/ID holds a real instruction (0 = bubble).
- parado  out  1  FSM is in FIM (PC out of range).
- erro_alinhamento  out  1  sticky: a misaligned target was received.
- instrucoes_emitidas  out  32  count of valid instructions written into IF/ID.

## Operation
- FSM states: BUSCA, FIM. Reset enters BUSCA.
- Range check: `em_faixa` = (pc < 4*TAM_MEM), unsigned compare.
- Priority per rising edge: reset > desvio > stall > normal.
- reset:
  - pc <= PC_INICIAL; state <= BUSCA.
  - instrucao_id <= 0 (nop); pc_mais4_id <= 0; valido_id <= 0.
  - erro_alinhamento <= 0; instrucoes_emitidas <= 0.
- desvio (either state, stall ignored):
  - pc <= {alvo_desvio[31:2], 2'b00}.
  - IF/ID flushed: instrucao_id <= 0, valido_id <= 0, pc_mais4_id unchanged.
  - If alvo_desvio[1:0] != 0, erro_alinhamento <= 1 (sticky until reset).
  - Next state is BUSCA if the aligned target is < 4*TAM_MEM, else FIM.
- stall (no desvio): pc, IF/ID, counter and state all hold.
- Normal, state BUSCA and em_faixa:
  - instrucao_id <= instrucao; pc_mais4_id <= pc+4; valido_id <= 1.
  - pc <= pc+4 (32-bit, wraps modulo 2^32).
  - instrucoes_emitidas <= instrucoes_emitidas+1 (wraps).
- Normal, state BUSCA and !em_faixa:
  - state <= FIM; pc holds.
  - IF/ID takes a bubble (instrucao_id <= 0, valido_id <= 0).
- Normal, state FIM: pc holds; IF/ID takes a bubble every cycle; no count increment. Only desvio or reset leave FIM.
- parado = (state == FIM), combinational from the state register.

## Timing
- endereco = pc register; no added latency. The word for address A is in instrucao_id one edge after pc == A, assuming no stall or desvio.
- Redirect penalty: the edge that samples desvio=1 loads pc=target and writes a bubble to ID. The target instruction reaches ID on the following edge.
- Stall asserted for N cycles holds IF/ID for N cycles, so the decode stage sees the same instruction N+1 cycles.
- desvio and stall in the same cycle: desvio wins and the flush occurs.
- reset in the same cycle as desvio or stall: reset wins.
- Outputs are registered, except endereco (the pc register) and parado (decoded from the state register).

## Test plan
- Reset, then 3 free-running edges. Memory holds word0=32'h01095020, word1=32'h02119020, word2=32'h02939822. Required:
  - endereco steps 0 → 4 → 8 → 12.
  - instrucao_id shows 01095020, then 02119020, then 02939822, each with valido_id=1.
  - pc_mais4_id shows 4, 8, 12.
  - instrucoes_emitidas = 3.
- Stall held 2 cycles while pc=8 → pc stays 8, instrucao_id stays 02119020, count stays 2. After release, the next edge loads word2 and pc=12.
- desvio=1, alvo_desvio=80, with stall=1 in the same cycle:
  - Next edge: pc=80, valido_id=0, instrucao_id=0.
  - Following edge: instrucao_id = word20, pc_mais4_id=84.
- Misaligned target alvo_desvio=22 → pc=20 and erro_alinhamento=1. The flag stays 1 through later normal fetches and clears only on reset.
- TAM_MEM=32, run to pc=124:
  - Edge at pc=124 fetches word31; pc becomes 128.
  - Next edge: parado=1, valido_id=0, pc holds 128, count frozen.
  - desvio to 20 → parado=0, fetch resumes at 20.
- reset asserted mid-run while desvio=1 → pc=0, valido_id=0, count=0, parado=0, erro_alinhamento=0.
